// File: rtl/goldschmidt_div_sequencer_pkg.sv
// goldschmidt_pkg: shared Q4.12 constants and FSM state type for the
// goldschmidt divider request sequencer.
// Contents:
//   Q_W, Q_FRAC   fixed-point word width and fraction bits
//   Q_ZERO, Q_ONE 0.0 and 1.0 in Q4.12
//   state_t       sequencer FSM states
package goldschmidt_pkg;

  localparam int          Q_W    = 16;
  localparam int          Q_FRAC = 12;
  localparam logic [15:0] Q_ZERO = 16'h0000;
  localparam logic [15:0] Q_ONE  = 16'(32'd1 << Q_FRAC);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/goldschmidt_div_sequencer_fifo.sv
// gs_req_fifo: synchronous request FIFO. Head entry is presented
// combinationally on pop_data while not empty.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (ignored when full, even with a same-cycle pop)
//   pop         retire head entry (ignored when empty)
//   pop_data    current head entry
//   full/empty  registered-count status flags
//   count       number of stored entries
module gs_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == (AW + 1)'(0));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/goldschmidt_div_sequencer.sv
// goldschmidt_div_sequencer: request front-end for goldschmidt_divider
// (unsigned Q4.12). Buffers tagged requests, issues them one at a time
// with a one-cycle div_start pulse, waits for div_valid (or a timeout)
// and returns quotient/error/tag on a valid/ready result port.
// Optional build macro: DIV_ZERO_BYPASS_EN -- a zero denominator is
// answered with an error directly, without starting the divider.
// Ports:
//   in_valid/in_ready/in_num/in_den/in_tag     request port
//   out_valid/out_ready/out_quot/out_err/
//   out_tmo/out_tag                             result port
//   div_start/div_num/div_den                   divider control (registered)
//   div_quot/div_valid/div_error                divider response
module goldschmidt_div_sequencer
  import goldschmidt_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_num,
  input  logic [15:0]      in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_quot,
  output logic             out_err,
  output logic             out_tmo,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_start,
  output logic [15:0]      div_num,
  output logic [15:0]      div_den,
  input  logic [15:0]      div_quot,
  input  logic             div_valid,
  input  logic             div_error
);

  localparam int ENT_W = TAG_W + 2 * Q_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [TAG_W-1:0] tag_r;
  logic             bypass_r;
  logic             out_valid_r;
  logic [15:0]      out_quot_r;
  logic             out_err_r;
  logic             out_tmo_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             div_start_r;
  logic [15:0]      div_num_r;
  logic [15:0]      div_den_r;

  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic [ENT_W-1:0] head_s;
  logic [15:0]      head_num_s;
  logic [15:0]      head_den_s;
  logic [TAG_W-1:0] head_tag_s;
  logic             head_bypass_s;

  assign in_ready   = (count_s != CNT_W'(FIFO_DEPTH));
  assign push_s     = in_valid && !full_s;
  // Head is retired on the IDLE->ISSUE edge, when it is latched.
  assign pop_s      = (state_r == IDLE) && !empty_s;
  assign head_num_s = head_s[Q_W-1:0];
  assign head_den_s = head_s[2*Q_W-1:Q_W];
  assign head_tag_s = head_s[ENT_W-1:2*Q_W];

`ifdef DIV_ZERO_BYPASS_EN
  assign head_bypass_s = (head_den_s == Q_ZERO);
`else
  assign head_bypass_s = 1'b0;
`endif

  gs_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({in_tag, in_den, in_num}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Issue/wait/respond sequencer; all divider and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= TMO_W'(0);
      tag_r       <= TAG_W'(0);
      bypass_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_quot_r  <= Q_ZERO;
      out_err_r   <= 1'b0;
      out_tmo_r   <= 1'b0;
      out_tag_r   <= TAG_W'(0);
      div_start_r <= 1'b0;
      div_num_r   <= Q_ZERO;
      div_den_r   <= Q_ZERO;
    end else begin
      div_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            state_r     <= ISSUE;
            div_num_r   <= head_num_s;
            div_den_r   <= head_den_s;
            tag_r       <= head_tag_s;
            bypass_r    <= head_bypass_s;
            div_start_r <= !head_bypass_s;
          end
        end
        ISSUE: begin
          if (bypass_r) begin
            state_r     <= RESP;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b1;
            out_tmo_r   <= 1'b0;
            out_quot_r  <= Q_ZERO;
            out_tag_r   <= tag_r;
          end else begin
            state_r <= GUARD;
          end
        end
        // div_valid may still be the previous op's level here.
        GUARD: begin
          state_r   <= WAIT;
          tmo_cnt_r <= TMO_W'(0);
        end
        WAIT: begin
          if (div_valid) begin
            state_r     <= RESP;
            out_valid_r <= 1'b1;
            out_err_r   <= div_error;
            out_tmo_r   <= 1'b0;
            out_quot_r  <= div_error ? Q_ZERO : div_quot;
            out_tag_r   <= tag_r;
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_r     <= RESP;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b1;
            out_tmo_r   <= 1'b1;
            out_quot_r  <= Q_ZERO;
            out_tag_r   <= tag_r;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        RESP: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_quot  = out_quot_r;
  assign out_err   = out_err_r;
  assign out_tmo   = out_tmo_r;
  assign out_tag   = out_tag_r;
  assign div_start = div_start_r;
  assign div_num   = div_num_r;
  assign div_den   = div_den_r;

endmodule

// File: tb/tb_goldschmidt_div_sequencer.sv
// Self-checking bench for goldschmidt_div_sequencer. A behavioural divider
// stand-in (random latency, stale valid level held into the next op,
// optional "never valid" stub mode) drives the divider-side inputs.
module tb_goldschmidt_div_sequencer;
  import goldschmidt_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int TMO   = 64;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_num;
  logic [15:0]   in_den;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_quot;
  logic          out_err;
  logic          out_tmo;
  logic [TW-1:0] out_tag;
  logic          div_start;
  logic [15:0]   div_num;
  logic [15:0]   div_den;
  logic [15:0]   div_quot  = 16'h0000;
  logic          div_valid = 1'b0;
  logic          div_error = 1'b0;

  always #5 clk = ~clk;

  goldschmidt_div_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TAG_W       (TW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_err   (out_err),
    .out_tmo   (out_tmo),
    .out_tag   (out_tag),
    .div_start (div_start),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_quot  (div_quot),
    .div_valid (div_valid),
    .div_error (div_error)
  );

  // ---------------- divider stand-in ----------------
  logic stub        = 1'b0;
  logic busy        = 1'b0;
  int   dcnt        = 0;
  int   start_cnt   = 0;

  function automatic logic [15:0] div_fn(input logic [15:0] n, input logic [15:0] d);
    logic [31:0] q;
    if (d == 16'h0000) return 16'hFFFF;
    q = {4'h0, n, 12'h000} / {16'h0000, d};
    return q[15:0];
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      busy      <= 1'b1;
      dcnt      <= $urandom_range(1, 6);
    end else if (busy) begin
      if (dcnt == 1) begin
        busy      <= 1'b0;
        div_valid <= !stub;
        div_error <= (div_den == 16'h0000);
        div_quot  <= div_fn(div_num, div_den);
      end else begin
        div_valid <= 1'b0;
        dcnt      <= dcnt - 1;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [15:0]   q;
    logic          err;
    logic          tmo;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic [15:0]   num;
    logic [15:0]   den;
    logic [TW-1:0] tag;
    logic [15:0]   exp_q;
    logic          exp_err;
  } vec_t;

  res_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic res_t model(input logic [15:0] n, input logic [15:0] d,
                                 input logic [TW-1:0] t);
    res_t r;
    r.tag = t;
    r.tmo = 1'b0;
    if (d == 16'h0000) begin
      r.q   = 16'h0000;
      r.err = 1'b1;
    end else begin
      r.q   = 16'((int'(n) * 4096) / int'(d));
      r.err = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [15:0] act, input logic [15:0] exp);
    int d;
    d = int'(act) - int'(exp);
    tests++;
    if (d > 1 || d < -1) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (+/-1)", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk_q({nm, "_quot"}, out_quot, e.q);
      chk({nm, "_err"}, {31'd0, out_err}, {31'd0, e.err});
      chk({nm, "_tmo"}, {31'd0, out_tmo}, {31'd0, e.tmo});
      chk({nm, "_tag"}, {28'd0, out_tag}, {28'd0, e.tag});
    end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic push_one(input logic [15:0] n, input logic [15:0] d, input logic [TW-1:0] t);
    int k;
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    in_tag   = t;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("push_accept", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("wait_out_valid", 32'd0, 32'd1);
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    @(negedge clk);
    while (!div_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!div_start) chk("wait_div_start", 32'd0, 32'd1);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("resp_cleared", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_div_start"}, {31'd0, div_start}, 32'd0);
    chk({nm, "_outs"}, {12'd0, out_quot, out_err, out_tmo, out_tag}, 32'd0);
    chk({nm, "_div_ops"}, {div_num, div_den}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   s0;
    int   n_push;
    int   n_got;
    int   cyc;
    logic [15:0] rn;
    logic [15:0] rd;

    vecs[0] = '{16'h2000, Q_ONE,    4'd1, 16'h2000, 1'b0};
    vecs[1] = '{16'h1000, 16'h2000, 4'd2, 16'h0800, 1'b0};
    vecs[2] = '{16'h2000, 16'h7000, 4'd3, 16'h0492, 1'b0};
    vecs[3] = '{16'h2C00, 16'h1400, 4'd4, 16'h2333, 1'b0};
    vecs[4] = '{16'h2000, 16'h0000, 4'd5, 16'h0000, 1'b1};
    vecs[5] = '{16'h0000, 16'h1000, 4'd6, 16'h0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_num    = 16'h0000;
    in_den    = 16'h0000;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed vectors, one at a time.
    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      push_one(vecs[i].num, vecs[i].den, vecs[i].tag);
      wait_out(lat);
      chk_q($sformatf("vec%0d_quot", i), out_quot, vecs[i].exp_q);
      chk($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_tmo", i), {31'd0, out_tmo}, 32'd0);
      chk($sformatf("vec%0d_tag", i), {28'd0, out_tag}, {28'd0, vecs[i].tag});
      if (BYPASS && vecs[i].den == 16'h0000) begin
        chk($sformatf("vec%0d_starts", i), start_cnt - s0, 32'd0);
        chk($sformatf("vec%0d_bypass_lat", i), lat, 32'd2);
      end else begin
        chk($sformatf("vec%0d_starts", i), start_cnt - s0, 32'd1);
      end
      take_result();
    end

    // Back-pressure: six back-to-back pushes with out_ready low.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_num   = 16'(16'h1000 * (i + 1));
      in_den   = 16'h2000;
      in_tag   = TW'(i + 8);
      @(negedge clk);
      chk($sformatf("fill%0d_in_ready", i), {31'd0, in_ready}, (i < 5) ? 32'd1 : 32'd0);
      if (in_valid && in_ready) exp_q.push_back(model(in_num, in_den, in_tag));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_out(lat);
    repeat (3) tick();
    chk("fill_full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    n_got = 0;
    cyc = 0;
    while (n_got < 5 && cyc < 400) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        sb_check("fill");
        n_got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("fill_results", n_got, 32'd5);
    out_ready = 1'b0;
    tick();

    // Randomized traffic against the reference model.
    n_push = 0;
    n_got  = 0;
    cyc    = 0;
    while ((n_push < 80 || exp_q.size() != 0) && cyc < 6000) begin
      if (n_push < 80 && $urandom_range(0, 1) == 1) begin
        rn = 16'($urandom_range(0, 16'h7FFF));
        rd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(16'h0800, 16'hFFFF));
        in_valid = 1'b1;
        in_num   = rn;
        in_den   = rd;
        in_tag   = TW'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_num, in_den, in_tag));
        n_push++;
      end
      if (out_valid && out_ready) begin
        sb_check("rand");
        n_got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_results", n_got, 32'd80);
    tick();

    // Divider never answers: timeout exactly TMO cycles after entering WAIT.
    stub = 1'b1;
    in_valid = 1'b1;
    in_num   = 16'h3000;
    in_den   = 16'h1000;
    in_tag   = 4'hA;
    wait_start();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 2; n <= TMO + 1; n++) tick();
    chk("tmo_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("tmo_valid", {31'd0, out_valid}, 32'd1);
    chk("tmo_err", {31'd0, out_err}, 32'd1);
    chk("tmo_flag", {31'd0, out_tmo}, 32'd1);
    chk("tmo_quot", {16'd0, out_quot}, 32'd0);
    chk("tmo_tag", {28'd0, out_tag}, 32'hA);
    take_result();

    // Asynchronous reset while waiting on the divider.
    in_valid = 1'b1;
    in_num   = 16'h4000;
    in_den   = 16'h1000;
    in_tag   = 4'h3;
    wait_start();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    stub  = 1'b0;
    exp_q.delete();
    tick();
    push_one(16'h1000, 16'h2000, 4'h7);
    wait_out(lat);
    chk_q("postrst_quot", out_quot, 16'h0800);
    chk("postrst_err", {31'd0, out_err}, 32'd0);
    chk("postrst_tag", {28'd0, out_tag}, 32'h7);
    take_result();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
